// File: rtl/demux_1to2_if.sv
// demux_1to2_if: signal bundle between one producer and the demux.
//   master : drives sel/in/en, observes y0/y1 (producer / testbench side)
//   slave  : samples sel/in/en, drives y0/y1 (demux side)
//   WIDTH  : data width of in/y0/y1 (1..64), must match the demux WIDTH
interface demux_1to2_if #(
  parameter int WIDTH = 1
);
  logic             sel;
  logic [WIDTH-1:0] in;
  logic             en;
  logic [WIDTH-1:0] y0;
  logic [WIDTH-1:0] y1;

  modport master (output sel, in, en, input  y0, y1);
  modport slave  (input  sel, in, en, output y0, y1);
endinterface

// File: rtl/demux_1to2.sv
// demux_1to2: registered 1-to-2 demultiplexer with enable.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears both outputs
//   bus   : slave side of demux_1to2_if
//           sel   - 0 routes in to y0, 1 routes in to y1
//           in    - WIDTH-bit data
//           en    - 0 forces both outputs to zero
//           y0/y1 - registered outputs, one-cycle latency
// The unselected output always loads zero, so at most one output is ever
// nonzero and a port switch happens in one cycle with no overlap.
module demux_1to2 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_1to2_if.slave  bus
);

  logic [WIDTH-1:0] y0_d, y0_q;
  logic [WIDTH-1:0] y1_d, y1_q;

  always_comb begin
    y0_d = '0;
    y1_d = '0;
    if (bus.en) begin
      if (bus.sel) y1_d = bus.in;
      else         y0_d = bus.in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_q <= '0;
      y1_q <= '0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  // Outputs come straight from flops: glitch-free between edges.
  assign bus.y0 = y0_q;
  assign bus.y1 = y1_q;

endmodule

// File: tb/tb_demux_1to2.sv
// tb_demux_1to2: directed self-checking bench for demux_1to2.
// Two instances share clk/rst_n: WIDTH=1 (routing, toggle, switch) and
// WIDTH=8 (wide data). Inputs change on the falling edge and outputs are
// sampled on the falling edge after the rising edge that loaded them.
module tb_demux_1to2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #50 clk = ~clk;

  demux_1to2_if #(.WIDTH(1)) b1 ();
  demux_1to2_if #(.WIDTH(8)) b8 ();

  demux_1to2 #(.WIDTH(1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  demux_1to2 #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    b1.en = 1'b1; b1.sel = 1'b1; b1.in = 1'b1;
    b8.en = 1'b1; b8.sel = 1'b1; b8.in = 8'h01;
    #5 rst_n = 1'b0;
    // Clock toggles while reset is held: outputs must stay zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b0) begin
      errors++; $display("FAIL reset_hold_w1: y0=%b y1=%b, required 0/0", b1.y0, b1.y1);
    end
    checks++;
    if (b8.y0 !== 8'h00 || b8.y1 !== 8'h00) begin
      errors++; $display("FAIL reset_hold_w8: y0=%h y1=%h, required 00/00", b8.y0, b8.y1);
    end
    // Release: first edge samples inputs normally.
    rst_n = 1'b1;
    tick();
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b1) begin
      errors++; $display("FAIL reset_release: y0=%b y1=%b, required 0/1", b1.y0, b1.y1);
    end
    tick(); tick();
    // Assert reset between edges: clear must be immediate.
    #10 rst_n = 1'b0;
    #1;
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b0 || b8.y1 !== 8'h00) begin
      errors++; $display("FAIL reset_async: y0=%b y1=%b y1w8=%h, required 0/0/00", b1.y0, b1.y1, b8.y1);
    end
    tick(); tick();
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b0) begin
      errors++; $display("FAIL reset_async_hold: y0=%b y1=%b, required 0/0", b1.y0, b1.y1);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (b1.y1 !== 1'b1 || b8.y1 !== 8'h01) begin
      errors++; $display("FAIL reset_resample: y1=%b y1w8=%h, required 1/01", b1.y1, b8.y1);
    end
    b8.en = 1'b0; b8.sel = 1'b0; b8.in = 8'h00;
  endtask

  // All 8 {en,sel,in} combinations; expected values from the routing table.
  task automatic test_routing();
    logic exp_y0 [8];
    logic exp_y1 [8];
    logic [2:0] v;
    exp_y0 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_y1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      b1.en = v[2]; b1.sel = v[1]; b1.in = v[0];
      tick();
      checks++;
      if (b1.y0 !== exp_y0[i] || b1.y1 !== exp_y1[i]) begin
        errors++;
        $display("FAIL routing{en,sel,in}=%b: y0=%b y1=%b, required %b/%b",
                 v, b1.y0, b1.y1, exp_y0[i], exp_y1[i]);
      end
    end
  endtask

  // in toggles each cycle, sel every 2, en every 4, starting all at 1.
  task automatic test_toggle();
    logic e, s, d, x0, x1;
    for (int k = 0; k < 16; k++) begin
      d = ((k % 2) == 0);
      s = (((k / 2) % 2) == 0);
      e = (((k / 4) % 2) == 0);
      b1.en = e; b1.sel = s; b1.in = d;
      tick();
      x0 = (e && !s) ? d : 1'b0;
      x1 = (e &&  s) ? d : 1'b0;
      checks++;
      if (b1.y0 !== x0 || b1.y1 !== x1 || (b1.y0 & b1.y1) !== 1'b0) begin
        errors++;
        $display("FAIL toggle_cycle%0d: y0=%b y1=%b, required %b/%b", k, b1.y0, b1.y1, x0, x1);
      end
    end
  endtask

  task automatic test_wide();
    b8.en = 1'b1; b8.sel = 1'b0; b8.in = 8'hA5;
    tick();
    checks++;
    if (b8.y0 !== 8'hA5 || b8.y1 !== 8'h00) begin
      errors++; $display("FAIL wide_y0: y0=%h y1=%h, required a5/00", b8.y0, b8.y1);
    end
    b8.sel = 1'b1; b8.in = 8'h3C;
    tick();
    checks++;
    if (b8.y0 !== 8'h00 || b8.y1 !== 8'h3C) begin
      errors++; $display("FAIL wide_y1: y0=%h y1=%h, required 00/3c", b8.y0, b8.y1);
    end
    b8.en = 1'b0; b8.in = 8'hFF;
    tick();
    checks++;
    if (b8.y0 !== 8'h00 || b8.y1 !== 8'h00) begin
      errors++; $display("FAIL wide_disabled: y0=%h y1=%h, required 00/00", b8.y0, b8.y1);
    end
    // Mid-operation reset: no stale A5 may reappear after release.
    b8.en = 1'b1; b8.sel = 1'b0; b8.in = 8'hA5;
    tick();
    #10 rst_n = 1'b0;
    #1;
    checks++;
    if (b8.y0 !== 8'h00) begin
      errors++; $display("FAIL wide_reset_mid: y0=%h, required 00", b8.y0);
    end
    @(negedge clk);
    b8.en = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (b8.y0 !== 8'h00 || b8.y1 !== 8'h00) begin
      errors++; $display("FAIL wide_no_stale: y0=%h y1=%h, required 00/00", b8.y0, b8.y1);
    end
  endtask

  task automatic test_back_to_back();
    b1.en = 1'b1; b1.sel = 1'b0; b1.in = 1'b1;
    tick();
    checks++;
    if (b1.y0 !== 1'b1 || b1.y1 !== 1'b0) begin
      errors++; $display("FAIL switch_before: y0=%b y1=%b, required 1/0", b1.y0, b1.y1);
    end
    b1.sel = 1'b1; b1.en = 1'b0;
    tick();
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b0) begin
      errors++; $display("FAIL switch_after: y0=%b y1=%b, required 0/0", b1.y0, b1.y1);
    end
    tick();
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b0) begin
      errors++; $display("FAIL switch_settled: y0=%b y1=%b, required 0/0", b1.y0, b1.y1);
    end
    // Direct port hop y0 -> y1 in a single cycle.
    b1.en = 1'b1; b1.sel = 1'b0; b1.in = 1'b1;
    tick();
    b1.sel = 1'b1;
    tick();
    checks++;
    if (b1.y0 !== 1'b0 || b1.y1 !== 1'b1) begin
      errors++; $display("FAIL switch_hop: y0=%b y1=%b, required 0/1", b1.y0, b1.y1);
    end
  endtask

  initial begin
    b1.en = 1'b0; b1.sel = 1'b0; b1.in = '0;
    b8.en = 1'b0; b8.sel = 1'b0; b8.in = '0;
    test_reset();
    test_routing();
    test_toggle();
    test_wide();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
